// File: rtl/saturn_def_dbgfmt.sv
// Shared definitions for the Saturn debug register-dump formatter.
//   dbgf_state_e      : formatter FSM states, one state per emitted character class
//   ASCII_*           : fixed punctuation characters used in the dump text
//   dbgf_total_chars  : characters in one complete dump for a given field geometry
package saturn_def_dbgfmt;

  typedef enum logic [2:0] {
    DBGF_IDLE,
    DBGF_LBL0,
    DBGF_LBL1,
    DBGF_COLON,
    DBGF_SPACE,
    DBGF_DIGIT,
    DBGF_SEP,
    DBGF_DONE
  } dbgf_state_e;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Each field is "LL: " (4 chars) + hex digits + one separator.
  function automatic int unsigned dbgf_total_chars(input int unsigned n_fields,
                                                   input int unsigned nibbles);
    return n_fields * (nibbles + 5);
  endfunction

endpackage

// File: rtl/saturn_hex_ascii.sv
// Nibble to uppercase hexadecimal ASCII converter (purely combinational).
//   i_nibble : 4-bit value
//   o_ascii  : "0".."9" for 0..9, "A".."F" for 10..15
module saturn_hex_ascii (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_ascii
);

  always_comb begin
    if (i_nibble < 4'd10) begin
      o_ascii = 8'h30 + {4'h0, i_nibble};
    end else begin
      // 8'h37 + 10 == "A"
      o_ascii = 8'h37 + {4'h0, i_nibble};
    end
  end

endmodule

// File: rtl/saturn_debug_formatter.sv
// Saturn debug register-dump formatter.
// On a trigger, snapshots N_FIELDS hex fields and streams them as ASCII text,
// one "LL: hhhh" group per field, separated by a space or a line feed
// (LF after every FIELDS_PER_LINE fields and after the last field).
// Characters are generated on the fly from the snapshot; no string RAM.
//
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_clk_en        : qualifies every state change except reset
//   i_trigger       : dump request, sampled when i_clk_en is high
//   i_fields        : field k at [k*NIBBLES*4 +: NIBBLES*4]
//   o_busy          : high from trigger acceptance through the done cycle
//   o_char          : current ASCII character
//   o_char_valid    : o_char valid; held until i_clk_en && i_char_ready
//   i_char_ready    : sink accepts o_char
//   o_done          : high in the cycle after the final character transfer
//   o_dropped       : saturating count of triggers ignored while busy
module saturn_debug_formatter
  import saturn_def_dbgfmt::*;
#(
  parameter int unsigned N_FIELDS        = 8,
  parameter int unsigned NIBBLES         = 16,
  parameter int unsigned FIELDS_PER_LINE = 2,
  parameter logic [N_FIELDS*16-1:0] LABELS = "PCA B C D D0D1ST"
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_clk_en,
  input  logic                        i_trigger,
  input  logic [N_FIELDS*NIBBLES*4-1:0] i_fields,
  output logic                        o_busy,
  output logic [7:0]                  o_char,
  output logic                        o_char_valid,
  input  logic                        i_char_ready,
  output logic                        o_done,
  output logic [7:0]                  o_dropped
);

  localparam int unsigned IDX_W = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;
  localparam int unsigned PTR_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam int unsigned COL_W = (FIELDS_PER_LINE > 1) ? $clog2(FIELDS_PER_LINE) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FIELDS - 1);
  localparam logic [PTR_W-1:0] TOP_PTR  = PTR_W'(NIBBLES - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(FIELDS_PER_LINE - 1);

  // Snapshot viewed as [field][nibble][bit]; same bit layout as i_fields.
  typedef logic [N_FIELDS-1:0][NIBBLES-1:0][3:0] snap_t;
  // Labels viewed as [pair][char]; field 0 owns the most significant pair
  // and the upper byte of a pair is the first character printed.
  typedef logic [N_FIELDS-1:0][1:0][7:0] label_t;
  localparam label_t LABEL_ARR = LABELS;

  dbgf_state_e      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [COL_W-1:0] col_q, col_d;
  snap_t            snap_q, snap_d;
  logic [7:0]       dropped_q, dropped_d;

  logic             char_valid;
  logic             xfer;
  logic             sep_is_lf;
  logic             last_field;
  logic [IDX_W-1:0] lbl_sel;
  logic [3:0]       cur_nibble;
  logic [7:0]       hex_char;
  logic [7:0]       char_out;

  assign char_valid = (state_q != DBGF_IDLE) && (state_q != DBGF_DONE);
  assign xfer       = i_clk_en && char_valid && i_char_ready;
  assign last_field = (idx_q == LAST_IDX);
  assign sep_is_lf  = (col_q == LAST_COL) || last_field;
  assign lbl_sel    = LAST_IDX - idx_q;
  assign cur_nibble = snap_q[idx_q][ptr_q];

  saturn_hex_ascii u_hex (
    .i_nibble (cur_nibble),
    .o_ascii  (hex_char)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    col_d   = col_q;
    snap_d  = snap_q;
    case (state_q)
      DBGF_IDLE: begin
        if (i_clk_en && i_trigger) begin
          state_d = DBGF_LBL0;
          snap_d  = i_fields;
          idx_d   = '0;
          ptr_d   = TOP_PTR;
          col_d   = '0;
        end
      end
      DBGF_LBL0:  if (xfer) state_d = DBGF_LBL1;
      DBGF_LBL1:  if (xfer) state_d = DBGF_COLON;
      DBGF_COLON: if (xfer) state_d = DBGF_SPACE;
      DBGF_SPACE: if (xfer) state_d = DBGF_DIGIT;
      DBGF_DIGIT: begin
        if (xfer) begin
          if (ptr_q == '0) begin
            state_d = DBGF_SEP;
          end else begin
            ptr_d = ptr_q - PTR_W'(1);
          end
        end
      end
      DBGF_SEP: begin
        if (xfer) begin
          if (last_field) begin
            state_d = DBGF_DONE;
          end else begin
            state_d = DBGF_LBL0;
            idx_d   = idx_q + IDX_W'(1);
            ptr_d   = TOP_PTR;
            col_d   = sep_is_lf ? '0 : col_q + COL_W'(1);
          end
        end
      end
      DBGF_DONE: if (i_clk_en) state_d = DBGF_IDLE;
      default:   state_d = DBGF_IDLE;
    endcase
  end

  // Triggers that arrive while a dump is in flight, including the done cycle.
  always_comb begin
    dropped_d = dropped_q;
    if (i_clk_en && i_trigger && (state_q != DBGF_IDLE) && (dropped_q != 8'hFF)) begin
      dropped_d = dropped_q + 8'd1;
    end
  end

  // Character currently offered to the sink.
  always_comb begin
    char_out = 8'h00;
    case (state_q)
      DBGF_LBL0:  char_out = LABEL_ARR[lbl_sel][1];
      DBGF_LBL1:  char_out = LABEL_ARR[lbl_sel][0];
      DBGF_COLON: char_out = ASCII_COLON;
      DBGF_SPACE: char_out = ASCII_SPACE;
      DBGF_DIGIT: char_out = hex_char;
      DBGF_SEP:   char_out = sep_is_lf ? ASCII_LF : ASCII_SPACE;
      default:    char_out = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= DBGF_IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      col_q     <= '0;
      snap_q    <= '0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ptr_q     <= ptr_d;
      col_q     <= col_d;
      snap_q    <= snap_d;
      dropped_q <= dropped_d;
    end
  end

  assign o_busy       = (state_q != DBGF_IDLE);
  assign o_char       = char_out;
  assign o_char_valid = char_valid;
  assign o_done       = (state_q == DBGF_DONE);
  assign o_dropped    = dropped_q;

endmodule
